uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001: The block SHALL have parameter DEPTH, default 16, setting FIFO entries; it must be a power of two and at least 2.
REQ-002: The block SHALL have parameter ADDR_W, default $clog2(DEPTH), setting the pointer width.
REQ-003: The block SHALL have port clk, input, width 1: the single clock; all logic is rising-edge.
REQ-004: The block SHALL have port rst, input, width 1: asynchronous, active-high reset.
REQ-005: The block SHALL have port wr_data, input, width 8: byte to enqueue.
REQ-006: The block SHALL have port wr_en, input, width 1: enqueue strobe, sampled each clk edge.
REQ-007: The block SHALL have port full, output, width 1: FIFO holds DEPTH bytes.
REQ-008: The block SHALL have port empty, output, width 1: FIFO holds 0 bytes.
REQ-009: The block SHALL have port count, output, width ADDR_W+1: current occupancy.
REQ-010: The block SHALL have port tx_data, output, width 8: byte presented to the uart_tx data input.
REQ-011: The block SHALL have port tx_data_ready, output, width 1: one-cycle launch strobe to uart_tx.
REQ-012: The block SHALL have port tx_done, input, width 1: level from uart_tx; high = transmitter idle, low = busy.
REQ-013: The block SHALL have port overflow, output, width 1: sticky dropped-write flag (see Configuration).

Function
REQ-014: A write with wr_en=1 and full=0 SHALL store wr_data and increment count on that edge.
REQ-015: A write with wr_en=1 and full=1 SHALL be dropped, even if a pop occurs on the same edge.
REQ-016: A simultaneous write and pop SHALL leave count unchanged, and both SHALL take effect.
REQ-017: Read and write pointers SHALL wrap modulo DEPTH; full/empty SHALL derive from count.
REQ-018: The launch FSM SHALL have exactly the states IDLE, WAIT_BUSY and WAIT_DONE.
REQ-019: In IDLE with empty=0 and tx_done=1, the block SHALL, on the next edge, pop the head byte into tx_data, drive tx_data_ready=1 for exactly one cycle, and move to WAIT_BUSY.
REQ-020: In IDLE with tx_done=0, no launch SHALL occur.
REQ-021: In WAIT_BUSY, tx_done=0 SHALL move the FSM to WAIT_DONE.
REQ-022: In WAIT_BUSY, 4 cycles elapsing without tx_done falling SHALL return the FSM to IDLE; this covers an instant-complete transmitter.
REQ-023: In WAIT_DONE, tx_done=1 SHALL move the FSM to IDLE.
REQ-024: Latency from a write edge into an empty FIFO with an idle FSM SHALL be 1 cycle to tx_data_ready=1.
REQ-025: tx_data SHALL hold its value from launch until the next launch.
REQ-026: Back-to-back bytes SHALL be separated by at least one IDLE cycle.

Reset
REQ-027: rst=1 SHALL asynchronously force count=0, empty=1, full=0, tx_data=8'h00, tx_data_ready=0, overflow=0, pointers=0 and FSM=IDLE.
REQ-028: Reset asserted mid-transmission SHALL discard queued bytes and SHALL NOT re-launch until a new write.
REQ-029: FIFO storage RAM SHALL NOT be reset.

Configuration
REQ-030: With macro UART_TX_FIFO_OVERFLOW_EN defined, overflow SHALL set on any dropped write and remain set until rst.
REQ-031: Without UART_TX_FIFO_OVERFLOW_EN, overflow SHALL be tied to 0 and no flag register SHALL exist.

Structure
REQ-032: Shared package uart_pkg SHALL hold the FSM state typedef (IDLE/WAIT_BUSY/WAIT_DONE), the WAIT_BUSY timeout constant (4) and the default DEPTH (16).
REQ-033: Storage and pointers SHALL be one sub-module, sync_fifo; the launch FSM SHALL live in uart_tx_fifo.

Verification
REQ-034: Scenario: write 8'h63 into an idle block driving uart_tx (CLK_PER_BIT=100) looped to uart_rx -> tx_data_ready pulses 1 cycle after the write, and uart_rx delivers 8'h63.
REQ-035: Scenario: burst-write 8'h41,8'h42,8'h43 on consecutive cycles -> uart_rx receives exactly 41,42,43 in order with no overlap; empty=1 after the third launch.
REQ-036: Scenario: DEPTH=16, tx_done held 0, write 17 bytes -> full=1, count=16, byte 17 dropped, overflow=1 only when UART_TX_FIFO_OVERFLOW_EN is defined.
REQ-037: Scenario: write and launch on the same edge when count=5 -> count stays 5.
REQ-038: Scenario: assert rst during WAIT_DONE with 3 bytes queued -> outputs return to reset values immediately, and no further tx_data_ready occurs after tx_done rises.
REQ-039: Scenario: tx_done tied 1 (never busy) -> FSM returns to IDLE after 4 WAIT_BUSY cycles and launches the next byte.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit FIFO: launch FSM states,
// WAIT_BUSY timeout and the default FIFO depth.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_t;

  localparam int BUSY_TIMEOUT  = 4;
  localparam int DEFAULT_DEPTH = 16;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write-side bundle of the transmit FIFO: byte and strobe in, occupancy
// status out. The master enqueues, the slave holds the storage.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);

  logic [7:0]      wr_data;
  logic            wr_en;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] count;

  modport master (output wr_data, wr_en, input full, empty, count);
  modport slave  (input wr_data, wr_en, output full, empty, count);

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous byte FIFO with first-word-fall-through read port.
// Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  wr,
  input  logic           rd_en,
  output logic [7:0]     rd_data
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              push;
  logic              pop;

  // A full FIFO refuses writes even when a pop lands on the same edge.
  assign push = wr.wr_en && !wr.full;
  assign pop  = rd_en && !wr.empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (ADDR_W + 1)'(1);
        2'b01:   cnt <= cnt - (ADDR_W + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr.wr_data;
  end

  assign rd_data  = mem[rd_ptr];
  assign wr.full  = (cnt == FULL_CNT);
  assign wr.empty = (cnt == '0);
  assign wr.count = cnt;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a UART transmitter with a launch FSM that pops one
// byte per transmission. Define UART_TX_FIFO_OVERFLOW_EN for a sticky overflow flag.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      wr_data,
  input  logic            wr_en,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] count,
  output logic [7:0]      tx_data,
  output logic            tx_data_ready,
  input  logic            tx_done,
  output logic            overflow
);

  localparam logic [1:0] BUSY_LAST = 2'(BUSY_TIMEOUT - 1);

  uart_tx_fifo_if #(.ADDR_W(ADDR_W)) fifo_bus ();

  tx_state_t  state;
  tx_state_t  state_next;
  logic [1:0] busy_cnt;
  logic       launch;
  logic [7:0] head;

  assign fifo_bus.wr_data = wr_data;
  assign fifo_bus.wr_en   = wr_en;
  assign full             = fifo_bus.full;
  assign empty            = fifo_bus.empty;
  assign count            = fifo_bus.count;

  sync_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr      (fifo_bus),
    .rd_en   (launch),
    .rd_data (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // WAIT_BUSY gives up after BUSY_TIMEOUT cycles so a transmitter that
  // finishes before ever dropping tx_done does not stall the queue.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!fifo_bus.empty && tx_done) state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!tx_done)                   state_next = WAIT_DONE;
        else if (busy_cnt == BUSY_LAST) state_next = IDLE;
      end
      WAIT_DONE: if (tx_done) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    launch = (state == IDLE) && !fifo_bus.empty && tx_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt      <= '0;
      tx_data       <= 8'h00;
      tx_data_ready <= 1'b0;
    end else begin
      tx_data_ready <= launch;
      if (launch) tx_data <= head;
      if (state != WAIT_BUSY) busy_cnt <= '0;
      else if (tx_done)       busy_cnt <= busy_cnt + 2'd1;
    end
  end

`ifdef UART_TX_FIFO_OVERFLOW_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          overflow <= 1'b0;
    else if (wr_en && fifo_bus.full)  overflow <= 1'b1;
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed vector table, corner-case sequences and
// a randomized run against a queue-based reference model.
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_data_ready;
  logic       tx_done;
  logic       overflow;

  uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_data       (bus.wr_data),
    .wr_en         (bus.wr_en),
    .full          (bus.full),
    .empty         (bus.empty),
    .count         (bus.count),
    .tx_data       (tx_data),
    .tx_data_ready (tx_data_ready),
    .tx_done       (tx_done),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       we;
    logic [7:0] d;
    logic       td;
    int         cnt;
    logic       emp;
    logic       ful;
    logic       rdy;
    logic [7:0] txd;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    tx_done     = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reference model state: queued bytes plus the transmitter slot status.
  byte unsigned q[$];
  bit           slot_busy;
  bit           saw_low;
  int           wait_age;
  logic [7:0]   m_txd;
  bit           m_ovf;
  bit           m_rdy;

  task automatic model_reset();
    q.delete();
    slot_busy = 0;
    saw_low   = 0;
    wait_age  = 0;
    m_txd     = 8'h00;
    m_ovf     = 0;
    m_rdy     = 0;
  endtask

  task automatic model_edge(input bit we, input logic [7:0] d, input bit td);
    bit accept;
    m_rdy  = !slot_busy && (q.size() > 0) && td;
    accept = we && (q.size() < DEPTH);
    if (we && !accept) m_ovf = OVF_EN;
    if (m_rdy) begin
      m_txd     = q.pop_front();
      slot_busy = 1;
      saw_low   = 0;
      wait_age  = 0;
    end else if (slot_busy) begin
      if (saw_low) begin
        if (td) slot_busy = 0;
      end else if (!td) begin
        saw_low = 1;
      end else begin
        wait_age++;
        if (wait_age == 4) slot_busy = 0;
      end
    end
    if (accept) q.push_back(d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_seen;
    logic [7:0] first_byte;

    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 1'b0, 8'h11};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h11};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h11};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 1'b0, 8'h11};
    tbl[8]  = '{1'b1, 8'h33, 1'b1, 1, 1'b0, 1'b0, 1'b1, 8'h22};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 1'b0, 8'h22};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 1'b0, 8'h22};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 1'b0, 8'h22};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 1'b0, 8'h22};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b1, 8'h33};
    tbl[14] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h33};

    // Reset values
    do_reset();
    chk("reset_count", 32'(bus.count), 0);
    chk("reset_empty", 32'(bus.empty), 1);
    chk("reset_full", 32'(bus.full), 0);
    chk("reset_tx_data", 32'(tx_data), 0);
    chk("reset_ready", 32'(tx_data_ready), 0);
    chk("reset_overflow", 32'(overflow), 0);

    // Directed vector table
    for (int i = 0; i < 15; i++) begin
      bus.wr_en   = tbl[i].we;
      bus.wr_data = tbl[i].d;
      tx_done     = tbl[i].td;
      tick();
      chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_empty", i), 32'(bus.empty), 32'(tbl[i].emp));
      chk($sformatf("vec%0d_full", i), 32'(bus.full), 32'(tbl[i].ful));
      chk($sformatf("vec%0d_ready", i), 32'(tx_data_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_tx_data", i), 32'(tx_data), 32'(tbl[i].txd));
    end

    // Write and launch on the same edge at count 5
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'h50 + i);
      tick();
    end
    chk("c5_count_before", 32'(bus.count), 5);
    bus.wr_data = 8'hA5;
    tx_done     = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    tx_done   = 1'b0;
    chk("c5_count_after", 32'(bus.count), 5);
    chk("c5_ready", 32'(tx_data_ready), 1);
    chk("c5_tx_data", 32'(tx_data), 32'h50);

    // Fill past DEPTH with the transmitter busy
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'h80 + i);
      tick();
    end
    chk("full_count", 32'(bus.count), DEPTH);
    chk("full_flag", 32'(bus.full), 1);
    chk("full_overflow", 32'(overflow), 32'(OVF_EN));
    bus.wr_data = 8'hEE;
    tx_done     = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    chk("full_pop_drop_count", 32'(bus.count), DEPTH - 1);
    chk("full_pop_ready", 32'(tx_data_ready), 1);
    chk("full_pop_tx_data", 32'(tx_data), 32'h80);
    chk("full_overflow_sticky", 32'(overflow), 32'(OVF_EN));

    // Reset during WAIT_DONE with 3 bytes queued
    do_reset();
    tx_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'hC0 + i);
      tick();
    end
    bus.wr_en = 1'b0;
    tx_done   = 1'b0;
    tick();
    chk("wd_count_queued", 32'(bus.count), 3);
    #2;
    rst = 1'b1;
    #1;
    chk("wd_async_count", 32'(bus.count), 0);
    chk("wd_async_empty", 32'(bus.empty), 1);
    chk("wd_async_tx_data", 32'(tx_data), 0);
    chk("wd_async_ready", 32'(tx_data_ready), 0);
    tick();
    rst     = 1'b0;
    tx_done = 1'b1;
    rdy_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (tx_data_ready === 1'b1) rdy_seen++;
    end
    chk("wd_no_relaunch", 32'(rdy_seen), 0);

    // Randomized run against the reference model
    do_reset();
    model_reset();
    first_byte = 8'h00;
    for (int i = 0; i < 600; i++) begin
      int ph;
      bit we, td;
      logic [7:0] d;
      ph = i / 150;
      case (ph)
        0:       begin we = ($urandom % 2) == 0; td = ($urandom % 4) != 0; end
        1:       begin we = ($urandom % 8) != 0; td = ($urandom % 8) == 0; end
        2:       begin we = ($urandom % 8) == 0; td = ($urandom % 4) != 0; end
        default: begin we = ($urandom % 2) == 0; td = ($urandom % 2) == 0; end
      endcase
      d = 8'($urandom);
      bus.wr_en   = we;
      bus.wr_data = d;
      tx_done     = td;
      model_edge(we, d, td);
      tick();
      chk($sformatf("rnd%0d_ready", i), 32'(tx_data_ready), 32'(m_rdy));
      chk($sformatf("rnd%0d_tx_data", i), 32'(tx_data), 32'(m_txd));
      chk($sformatf("rnd%0d_count", i), 32'(bus.count), 32'(q.size()));
      chk($sformatf("rnd%0d_empty", i), 32'(bus.empty), 32'(q.size() == 0));
      chk($sformatf("rnd%0d_full", i), 32'(bus.full), 32'(q.size() == DEPTH));
      chk($sformatf("rnd%0d_overflow", i), 32'(overflow), 32'(m_ovf));
    end
    bus.wr_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
